// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed little-endian program image over a byte stream,
// writes it to instruction memory from address 0 and releases the core on a good checksum.
`timescale 1ns/1ps
module imem_boot_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic [31:0]         mem_wdata,
    output logic                cpu_stall,
    output logic                done,
    output logic                error,
    output logic [ADDR_W:0]     words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t        state;
    state_t        next_state;
    logic [15:0]   len;
    logic [1:0]    lane;
    logic [23:0]   word_buf;
    logic [7:0]    csum;

    logic          accept;
    logic [15:0]   len_n;
    logic          len_bad;
    logic [16:0]   next_count;
    logic          last_word;

    assign in_ready   = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
    assign accept     = in_valid && in_ready;
    assign len_n      = {in_data, len[7:0]};
    assign len_bad    = (len_n == 16'd0) || ({1'b0, len_n} > MAX_LEN);
    assign next_count = 17'(words_loaded) + 17'd1;
    assign last_word  = (next_count == {1'b0, len});

    // Status outputs are pure decodes of the state, so they are sticky until the next start.
    assign done      = (state == DONE);
    assign error     = (state == ERR);
    assign cpu_stall = (state != DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    next_state = LEN0;
                end
            end
            LEN0: begin
                if (accept) begin
                    next_state = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    next_state = len_bad ? ERR : DATA;
                end
            end
            DATA: begin
                if (accept && (lane == 2'd3) && last_word) begin
                    next_state = CSUM;
                end
            end
            CSUM: begin
                if (accept) begin
                    next_state = (in_data == csum) ? DONE : ERR;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bytes shift in from the top so that after three bytes word_buf holds {b2, b1, b0};
    // the fourth byte completes the word and is written one cycle after its handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len          <= '0;
            lane         <= '0;
            word_buf     <= '0;
            csum         <= '0;
            mem_we       <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        words_loaded <= '0;
                        csum         <= '0;
                        lane         <= '0;
                    end
                end
                LEN0: begin
                    if (accept) begin
                        len[7:0] <= in_data;
                    end
                end
                LEN1: begin
                    if (accept) begin
                        len[15:8] <= in_data;
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum <= csum ^ in_data;
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_waddr    <= words_loaded[ADDR_W-1:0];
                            mem_wdata    <= {in_data, word_buf};
                            words_loaded <= words_loaded + 1'b1;
                        end else begin
                            word_buf <= {in_data, word_buf[23:8]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
